// File: rtl/uart_msg_sender.sv
// Streams a fixed ASCII message (optionally CR/LF-terminated) into a uart transmit/tx_byte
// interface, either periodically or on request, with abort, completion pulse and message count.
module uart_msg_sender #(
    parameter int                   MSG_LEN    = 12,
    parameter logic [8*MSG_LEN-1:0] MSG        = "Hello World!",
    parameter bit                   APPEND_EOL = 1'b0,
    parameter bit                   MODE       = 1'b0,
    parameter int                   PERIOD     = 4194304
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        done,
    output logic [15:0] msg_count
);

    localparam int TOTAL   = MSG_LEN + (APPEND_EOL ? 2 : 0);
    localparam int IDX_W   = $clog2(TOTAL + 1);
    localparam int TIMER_W = $clog2(PERIOD + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX     = IDX_W'(TOTAL - 1);
    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(PERIOD - 1);
    localparam logic [1:0]         ACK_LIMIT    = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        ACK,
        DRAIN
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [TIMER_W-1:0] timer;
    logic [1:0]         ack_cnt;
    logic               abort_q;

    // Message characters first, then the optional CR, LF pair.
    function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] k);
        int                   ki;
        logic [8*MSG_LEN-1:0] sh;
        ki = int'(k);
        sh = '0;
        if (ki < MSG_LEN) begin
            sh = MSG >> (8 * (MSG_LEN - 1 - ki));
            return sh[7:0];
        end else if (ki == MSG_LEN) begin
            return 8'h0D;
        end else begin
            return 8'h0A;
        end
    endfunction

    // NOTE: all state and outputs use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            timer     <= TIMER_RELOAD;
            ack_cnt   <= '0;
            abort_q   <= 1'b0;
            transmit  <= 1'b0;
            tx_byte   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            msg_count <= '0;
        end else begin
            // NOTE: pulse outputs default low each cycle; only the launching branches raise them.
            transmit <= 1'b0;
            done     <= 1'b0;
            if (state != IDLE && abort) begin
                abort_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (MODE == 1'b0) begin
                        if (abort) begin
                            timer <= TIMER_RELOAD;
                        end else if (timer != '0) begin
                            timer <= timer - 1'b1;
                        end else if (!is_transmitting) begin
                            state    <= STROBE;
                            transmit <= 1'b1;
                            tx_byte  <= byte_at(idx);
                            busy     <= 1'b1;
                        end
                    end else if (start && !abort && !is_transmitting) begin
                        state    <= STROBE;
                        transmit <= 1'b1;
                        tx_byte  <= byte_at(idx);
                        busy     <= 1'b1;
                    end
                end

                STROBE: begin
                    state   <= ACK;
                    ack_cnt <= '0;
                end

                // A uart that never answers must not stall the sender.
                ACK: begin
                    if (is_transmitting || ack_cnt == ACK_LIMIT) begin
                        state <= DRAIN;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
                end

                DRAIN: begin
                    if (!is_transmitting) begin
                        if (abort_q || abort || idx == LAST_IDX) begin
                            state   <= IDLE;
                            idx     <= '0;
                            timer   <= TIMER_RELOAD;
                            busy    <= 1'b0;
                            abort_q <= 1'b0;
                            if (idx == LAST_IDX) begin
                                done      <= 1'b1;
                                msg_count <= msg_count + 1'b1;
                            end
                        end else begin
                            state    <= STROBE;
                            idx      <= idx + 1'b1;
                            transmit <= 1'b1;
                            tx_byte  <= byte_at(idx + 1'b1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_sender.sv
// Directed bench for uart_msg_sender: four instances (triggered, CR/LF, periodic, silent uart)
// each driven by a simple uart model that holds is_transmitting for 10 cycles after a strobe.
module tb_uart_msg_sender;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic start_c = 1'b0, abort_c = 1'b0;
    logic start_d = 1'b0, abort_d = 1'b0;
    logic itx_d = 1'b0;
    logic itx_a, itx_b, itx_c;
    logic tx_a, tx_b, tx_c, tx_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic dn_a, dn_b, dn_c, dn_d;
    logic [7:0]  byte_a, byte_b, byte_c, byte_d;
    logic [15:0] mc_a, mc_b, mc_c, mc_d;

    uart_msg_sender #(.MODE(1'b1)) dut_a (
        .CLK(CLK), .rst_n(rst_n), .start(start_a), .abort(abort_a), .is_transmitting(itx_a),
        .transmit(tx_a), .tx_byte(byte_a), .busy(busy_a), .done(dn_a), .msg_count(mc_a));

    uart_msg_sender #(.MSG_LEN(2), .MSG("Hi"), .APPEND_EOL(1'b1), .MODE(1'b1)) dut_b (
        .CLK(CLK), .rst_n(rst_n), .start(start_b), .abort(abort_b), .is_transmitting(itx_b),
        .transmit(tx_b), .tx_byte(byte_b), .busy(busy_b), .done(dn_b), .msg_count(mc_b));

    uart_msg_sender #(.MSG_LEN(1), .MSG("Z"), .MODE(1'b0), .PERIOD(50)) dut_c (
        .CLK(CLK), .rst_n(rst_n), .start(start_c), .abort(abort_c), .is_transmitting(itx_c),
        .transmit(tx_c), .tx_byte(byte_c), .busy(busy_c), .done(dn_c), .msg_count(mc_c));

    uart_msg_sender #(.MODE(1'b1)) dut_d (
        .CLK(CLK), .rst_n(rst_n), .start(start_d), .abort(abort_d), .is_transmitting(itx_d),
        .transmit(tx_d), .tx_byte(byte_d), .busy(busy_d), .done(dn_d), .msg_count(mc_d));

    // uart models: busy from the cycle after a strobe, for 10 cycles; not cleared by rst_n
    int ucnt_a = 0, ucnt_b = 0, ucnt_c = 0;
    always @(posedge CLK) begin
        if (tx_a) ucnt_a <= 10; else if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
        if (tx_b) ucnt_b <= 10; else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
        if (tx_c) ucnt_c <= 10; else if (ucnt_c != 0) ucnt_c <= ucnt_c - 1;
    end
    assign itx_a = (ucnt_a != 0);
    assign itx_b = (ucnt_b != 0);
    assign itx_c = (ucnt_c != 0);

    // strobe/done recorders and per-cycle protocol checks
    logic [7:0] q_a[$], q_b[$], q_d[$];
    int ndone_a = 0, ndone_b = 0, ndone_d = 0;
    logic ptx_a = 1'b0, ptx_b = 1'b0, ptx_c = 1'b0, ptx_d = 1'b0;

    always @(negedge CLK) begin
        if (tx_a) q_a.push_back(byte_a);
        if (tx_b) q_b.push_back(byte_b);
        if (tx_d) q_d.push_back(byte_d);
        if (dn_a) ndone_a++;
        if (dn_b) ndone_b++;
        if (dn_d) ndone_d++;
        n_checks++;
        if ((tx_a && ptx_a) || (tx_b && ptx_b) || (tx_c && ptx_c) || (tx_d && ptx_d)) begin
            n_fail++;
            $display("FAIL consecutive_transmit: got tx=%b%b%b%b prev=%b%b%b%b required no back-to-back strobe",
                     tx_a, tx_b, tx_c, tx_d, ptx_a, ptx_b, ptx_c, ptx_d);
        end
        n_checks++;
        if ((tx_a && dn_a) || (tx_b && dn_b) || (tx_c && dn_c) || (tx_d && dn_d)) begin
            n_fail++;
            $display("FAIL done_with_transmit: got both high at %0t required never together", $time);
        end
        ptx_a = tx_a; ptx_b = tx_b; ptx_c = tx_c; ptx_d = tx_d;
    end

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_checks++;
        if ({tx_a, byte_a, busy_a, dn_a, mc_a} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_a: got tx=%b byte=%h busy=%b done=%b cnt=%0d required all zero",
                     tx_a, byte_a, busy_a, dn_a, mc_a);
        end
        n_checks++;
        if ({tx_b, byte_b, busy_b, dn_b, mc_b} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_b: got %h required 0", {tx_b, byte_b, busy_b, dn_b, mc_b});
        end
        n_checks++;
        if ({tx_c, byte_c, busy_c, dn_c, mc_c} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_c: got %h required 0", {tx_c, byte_c, busy_c, dn_c, mc_c});
        end
        n_checks++;
        if ({tx_d, byte_d, busy_d, dn_d, mc_d} !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_d: got %h required 0", {tx_d, byte_d, busy_d, dn_d, mc_d});
        end
    endtask

    // dut_c: PERIOD=50, one character 'Z'
    task automatic test_periodic();
        int first;
        int gap;
        first = -1;
        @(negedge CLK);
        rst_n = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (tx_c && first < 0) begin
                first = i;
                n_checks++;
                if (byte_c !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL periodic_byte: got %h required 5a", byte_c);
                end
            end
        end
        n_checks++;
        if (first != 50) begin
            n_fail++;
            $display("FAIL periodic_first_strobe: got cycle %0d required 50", first);
        end
        for (int m = 1; m <= 2; m++) begin
            for (int i = 0; i < 100 && !dn_c; i++) @(negedge CLK);
            n_checks++;
            if (dn_c !== 1'b1 || mc_c !== 16'(m)) begin
                n_fail++;
                $display("FAIL periodic_done_%0d: got done=%b count=%0d required 1 and %0d", m, dn_c, mc_c, m);
            end
            gap = 0;
            do begin
                @(negedge CLK);
                gap++;
            end while (!tx_c && gap < 200);
            n_checks++;
            if (gap != 50) begin
                n_fail++;
                $display("FAIL periodic_gap_%0d: got %0d cycles required 50", m, gap);
            end
        end
    endtask

    task automatic test_triggered();
        string exp;
        exp = "Hello World!";
        q_a.delete();
        @(negedge CLK);
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        n_checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b1 || byte_a !== 8'h48) begin
            n_fail++;
            $display("FAIL start_latency: got tx=%b busy=%b byte=%h required 1 1 48", tx_a, busy_a, byte_a);
        end
        for (int i = 0; i < 300 && !dn_a; i++) @(negedge CLK);
        repeat (20) @(negedge CLK);
        n_checks++;
        if (q_a.size() != 12) begin
            n_fail++;
            $display("FAIL hello_len: got %0d strobes required 12", q_a.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                n_checks++;
                if (q_a[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL hello_byte_%0d: got %h required %h", i, q_a[i], exp[i]);
                end
            end
        end
        n_checks++;
        if (ndone_a != 1 || mc_a !== 16'd1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL hello_done: got done=%0d count=%0d busy=%b required 1 1 0", ndone_a, mc_a, busy_a);
        end
    endtask

    task automatic test_eol();
        logic [7:0] exp[4];
        exp = '{8'h48, 8'h69, 8'h0D, 8'h0A};
        @(negedge CLK);
        start_b = 1'b1;
        @(negedge CLK);
        start_b = 1'b0;
        for (int i = 0; i < 200 && !dn_b; i++) @(negedge CLK);
        repeat (10) @(negedge CLK);
        n_checks++;
        if (q_b.size() != 4) begin
            n_fail++;
            $display("FAIL eol_len: got %0d strobes required 4", q_b.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (q_b[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL eol_byte_%0d: got %h required %h", i, q_b[i], exp[i]);
                end
            end
        end
        n_checks++;
        if (ndone_b != 1 || mc_b !== 16'd1) begin
            n_fail++;
            $display("FAIL eol_done: got done=%0d count=%0d required 1 1", ndone_b, mc_b);
        end
    endtask

    task automatic test_abort();
        int base_done;
        base_done = ndone_a;
        q_a.delete();
        @(negedge CLK);
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        for (int i = 0; i < 100 && q_a.size() < 3; i++) @(negedge CLK);
        repeat (3) @(negedge CLK);
        abort_a = 1'b1;
        @(negedge CLK);
        abort_a = 1'b0;
        repeat (40) @(negedge CLK);
        n_checks++;
        if (q_a.size() != 3) begin
            n_fail++;
            $display("FAIL abort_strobes: got %0d required 3", q_a.size());
        end
        n_checks++;
        if (busy_a !== 1'b0 || ndone_a != base_done || mc_a !== 16'd1) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done_delta=%0d count=%0d required 0 0 1",
                     busy_a, ndone_a - base_done, mc_a);
        end
        q_a.delete();
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        n_checks++;
        if (tx_a !== 1'b1 || byte_a !== 8'h48) begin
            n_fail++;
            $display("FAIL abort_restart: got tx=%b byte=%h required 1 48", tx_a, byte_a);
        end
        for (int i = 0; i < 300 && !dn_a; i++) @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (mc_a !== 16'd2 || q_a.size() != 12) begin
            n_fail++;
            $display("FAIL abort_restart_done: got count=%0d strobes=%0d required 2 12", mc_a, q_a.size());
        end
    endtask

    task automatic test_ack_timeout();
        int waited;
        @(negedge CLK);
        start_d = 1'b1;
        @(negedge CLK);
        start_d = 1'b0;
        waited = 0;
        while (!dn_d && waited < 300) begin
            @(negedge CLK);
            waited++;
        end
        n_checks++;
        if (dn_d !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_timeout_hang: got no done after %0d cycles required done", waited);
        end
        repeat (10) @(negedge CLK);
        n_checks++;
        if (q_d.size() != 12 || ndone_d != 1 || mc_d !== 16'd1) begin
            n_fail++;
            $display("FAIL ack_timeout_msg: got strobes=%0d done=%0d count=%0d required 12 1 1",
                     q_d.size(), ndone_d, mc_d);
        end else if (q_d[0] !== 8'h48 || q_d[11] !== 8'h21) begin
            n_fail++;
            $display("FAIL ack_timeout_bytes: got first=%h last=%h required 48 21", q_d[0], q_d[11]);
        end
    endtask

    task automatic test_back_to_back();
        int base_done;
        base_done = ndone_a;
        q_a.delete();
        @(negedge CLK);
        start_a = 1'b1;
        repeat (30) @(negedge CLK);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_busy: got %b required 1", busy_a);
        end
        start_a = 1'b0;
        for (int i = 0; i < 300 && !dn_a; i++) @(negedge CLK);
        repeat (30) @(negedge CLK);
        n_checks++;
        if (q_a.size() != 12 || ndone_a != base_done + 1 || mc_a !== 16'd3) begin
            n_fail++;
            $display("FAIL hold_start: got strobes=%0d done_delta=%0d count=%0d required 12 1 3",
                     q_a.size(), ndone_a - base_done, mc_a);
        end
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        repeat (40) @(negedge CLK);
        n_checks++;
        if (busy_a !== 1'b1 || byte_a === 8'h00) begin
            n_fail++;
            $display("FAIL pre_reset: got busy=%b byte=%h required busy 1 and nonzero byte", busy_a, byte_a);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_a, byte_a, busy_a, dn_a, mc_a} !== 27'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got tx=%b byte=%h busy=%b done=%b count=%0d required all zero",
                     tx_a, byte_a, busy_a, dn_a, mc_a);
        end
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (15) @(negedge CLK);
        start_a = 1'b1;
        @(negedge CLK);
        start_a = 1'b0;
        n_checks++;
        if (tx_a !== 1'b1 || byte_a !== 8'h48) begin
            n_fail++;
            $display("FAIL post_reset_start: got tx=%b byte=%h required 1 48", tx_a, byte_a);
        end
        for (int i = 0; i < 300 && !dn_a; i++) @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if (mc_a !== 16'd1) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d required 1", mc_a);
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_triggered();
        test_eol();
        test_abort();
        test_ack_timeout();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
